// File: rtl/counter_ctrl.sv
// Programmable timer controller: prescaled up-counter with one-shot/periodic
// modes, a terminal-count tick pulse and a sticky irq.
module counter_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_period,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_periodic,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  irq_clear,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tick,
  output logic                  irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [WIDTH-1:0]        period_q;
  logic [PRESCALE_W-1:0]   prescale_q;
  logic                    periodic_q;
  logic [PRESCALE_W-1:0]   pre, pre_n;
  logic [WIDTH-1:0]        count_n;
  logic                    tick_n, irq_n, busy_n;
  logic                    cfg_accept;

  // Handshake: a cfg transfer happens on any rising edge where cfg_valid and
  // cfg_ready are both high; cfg_ready depends on the state register only.
  assign cfg_ready  = (state != RUN);
  assign cfg_accept = cfg_valid && cfg_ready;

  // The cfg registers load on the start edge itself, so the RUN cycles that
  // follow already see a same-edge configuration.
  always_comb begin
    state_n = state;
    count_n = count;
    pre_n   = pre;
    tick_n  = 1'b0;
    irq_n   = irq & ~irq_clear;
    case (state)
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          pre_n   = '0;
        end else if (pre == prescale_q) begin
          pre_n = '0;
          if (count == period_q) begin
            tick_n = 1'b1;
            irq_n  = 1'b1;
            if (periodic_q) count_n = '0;
            else            state_n = HOLD;
          end else begin
            count_n = count + 1'b1;
          end
        end else begin
          pre_n = pre + 1'b1;
        end
      end
      default: begin
        if (start && !stop) begin
          state_n = RUN;
          count_n = '0;
          pre_n   = '0;
        end
      end
    endcase
    busy_n = (state_n == RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      pre        <= '0;
      tick       <= 1'b0;
      irq        <= 1'b0;
      busy       <= 1'b0;
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      pre   <= pre_n;
      tick  <= tick_n;
      irq   <= irq_n;
      busy  <= busy_n;
      if (cfg_accept) begin
        period_q   <= cfg_period;
        prescale_q <= cfg_prescale;
        periodic_q <= cfg_periodic;
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: elapsed-cycle arithmetic model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_counter_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_period = '0;
  logic [3:0] cfg_prescale = '0;
  logic       cfg_periodic = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       irq_clear = 1'b0;
  logic [7:0] count;
  logic       busy, tick, irq;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [7:0] exp_q[$];

  counter_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_prescale(cfg_prescale), .cfg_periodic(cfg_periodic),
    .start(start), .stop(stop), .irq_clear(irq_clear),
    .count(count), .busy(busy), .tick(tick), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs derived from cycles elapsed since the start edge.
  int m_count = 0, m_k = 0, m_pt = 0, m_ps = 0, m_len = 1;
  bit m_per = 1'b0, m_busy = 1'b0, m_tick = 1'b0, m_irq = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_count = 0; m_k = 0; m_pt = 0; m_ps = 0; m_per = 1'b0;
      m_busy = 1'b0; m_tick = 1'b0; m_irq = 1'b0;
    end else begin
      m_tick = 1'b0;
      m_irq  = m_irq && !irq_clear;
      if (m_busy) begin
        if (stop) begin
          m_busy = 1'b0;
        end else begin
          m_k++;
          m_len = (m_pt + 1) * (m_ps + 1);
          if (m_k % m_len == 0) begin
            m_tick = 1'b1;
            m_irq  = 1'b1;
            if (m_per) m_count = 0;
            else begin
              m_busy  = 1'b0;
              m_count = m_pt;
            end
          end else begin
            m_count = (m_k / (m_ps + 1)) % (m_pt + 1);
          end
        end
      end else begin
        if (cfg_valid) begin
          m_pt  = int'(cfg_period);
          m_ps  = int'(cfg_prescale);
          m_per = cfg_periodic;
        end
        if (start && !stop) begin
          m_busy  = 1'b1;
          m_k     = 0;
          m_count = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en && reset_n) begin
      check("m_count", int'(count), m_count);
      check("m_busy", int'(busy), int'(m_busy));
      check("m_tick", int'(tick), int'(m_tick));
      check("m_irq", int'(irq), int'(m_irq));
      check("m_cfg_ready", int'(cfg_ready), int'(!m_busy));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic launch(input int pt, input int ps, input bit per);
    cfg_valid    = 1'b1;
    cfg_period   = 8'(pt);
    cfg_prescale = 4'(ps);
    cfg_periodic = per;
    start        = 1'b1;
    cyc(1);
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    // Reset values while reset is held
    cyc(3);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_irq", int'(irq), 0);
    check("rst_ready", int'(cfg_ready), 1);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    cyc(1);

    // Periodic P_T=3, P_S=0
    launch(3, 0, 1'b1);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    for (int i = 0; i < 13; i++) begin
      check("per_count", int'(count), int'(exp_q.pop_front()));
      check("per_tick", int'(tick), (i == 4 || i == 8 || i == 12) ? 1 : 0);
      check("per_irq", int'(irq), (i >= 4) ? 1 : 0);
      cyc(1);
    end
    irq_clear = 1'b1;
    cyc(1);
    irq_clear = 1'b0;
    check("irq_clr", int'(irq), 0);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_hold", int'(count), 2);

    // One-shot P_T=2, P_S=2
    launch(2, 2, 1'b0);
    for (int i = 0; i <= 10; i++) begin
      if (i == 0) check("os_c0", int'(count), 0);
      if (i == 3) check("os_c3", int'(count), 1);
      if (i == 6) check("os_c6", int'(count), 2);
      if (i == 8) check("os_busy8", int'(busy), 1);
      if (i == 9) begin
        check("os_term_count", int'(count), 2);
        check("os_term_busy", int'(busy), 0);
        check("os_term_tick", int'(tick), 1);
        check("os_term_ready", int'(cfg_ready), 1);
      end
      if (i == 10) check("os_tick_once", int'(tick), 0);
      cyc(1);
    end
    // Rerun from HOLD, clearing irq first, then clear on the terminal edge
    start = 1'b1;
    irq_clear = 1'b1;
    cyc(1);
    start = 1'b0;
    irq_clear = 1'b0;
    check("rerun_count", int'(count), 0);
    check("rerun_busy", int'(busy), 1);
    check("rerun_irq", int'(irq), 0);
    for (int i = 0; i <= 10; i++) begin
      if (i == 9) begin
        check("setclr_irq", int'(irq), 1);
        check("setclr_tick", int'(tick), 1);
      end
      if (i == 10) check("clr_after", int'(irq), 0);
      irq_clear = (i == 8 || i == 9);
      cyc(1);
    end
    irq_clear = 1'b0;

    // stop+start on the same edge at count=1
    launch(5, 1, 1'b1);
    cyc(2);
    check("ss_pre_count", int'(count), 1);
    stop = 1'b1;
    start = 1'b1;
    cyc(1);
    stop = 1'b0;
    start = 1'b0;
    check("ss_busy", int'(busy), 0);
    check("ss_count", int'(count), 1);
    check("ss_tick", int'(tick), 0);
    cyc(1);
    check("ss_hold", int'(count), 1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("ss_restart_count", int'(count), 0);
    check("ss_restart_busy", int'(busy), 1);

    // cfg offered during RUN is refused; accepted on the first IDLE cycle
    cfg_valid = 1'b1;
    cfg_period = 8'd1;
    cfg_prescale = 4'd0;
    cfg_periodic = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("run_ready", int'(cfg_ready), 0);
      cyc(1);
    end
    check("run_old_cfg", int'(count), 2);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("idle_ready", int'(cfg_ready), 1);
    cyc(1);
    cfg_valid = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    exp_q = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
    for (int i = 0; i < 5; i++) begin
      check("new_cfg_count", int'(count), int'(exp_q.pop_front()));
      check("new_cfg_tick", int'(tick), (i == 2 || i == 4) ? 1 : 0);
      cyc(1);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;

    // P_T=0 loaded with start on the same edge; stop on a terminal step
    launch(0, 0, 1'b1);
    check("pt0_c0_tick", int'(tick), 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      check("pt0_tick", int'(tick), 1);
      check("pt0_count", int'(count), 0);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("pt0_stop_tick", int'(tick), 0);
    check("pt0_stop_busy", int'(busy), 0);

    // Maximum values, periodic
    irq_clear = 1'b1;
    launch(255, 15, 1'b1);
    irq_clear = 1'b0;
    for (int i = 0; i <= 4096; i++) begin
      if (i == 16) check("max_first_inc", int'(count), 1);
      if (i == 4095) begin
        check("max_top", int'(count), 255);
        check("max_irq_pre", int'(irq), 0);
      end
      if (i == 4096) begin
        check("max_wrap", int'(count), 0);
        check("max_tick", int'(tick), 1);
        check("max_irq", int'(irq), 1);
      end
      if (i < 4096) cyc(1);
    end
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;

    // Maximum period, one-shot
    launch(255, 0, 1'b0);
    cyc(255);
    check("os_max_top", int'(count), 255);
    check("os_max_busy", int'(busy), 1);
    cyc(1);
    check("os_max_hold", int'(count), 255);
    check("os_max_done", int'(busy), 0);
    check("os_max_tick", int'(tick), 1);

    // Asynchronous reset during RUN at count=5
    launch(10, 0, 1'b1);
    cyc(5);
    check("arst_pre_count", int'(count), 5);
    check("arst_pre_irq", int'(irq), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_tick", int'(tick), 0);
    check("arst_irq", int'(irq), 0);
    check("arst_busy", int'(busy), 0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    check("arst_ready", int'(cfg_ready), 1);
    check("arst_idle", int'(busy), 0);

    cyc(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
